it_block_ctrl: RTL and testbench
================================

// Module: it_block_ctrl
// PURPOSE
//  Thumb-2 IT-block controller. It sits between the xPSR and the execute/writeback stage.
//  - Consumes the APSR NZCV flags (xPSR read port, addr 0, bits [31:28]).
//  - Holds ITSTATE, which is the EPSR IT[7:0] field.
//  - Evaluates the condition of each instruction inside an IT block and advances
//    ITSTATE as instructions retire.
//  - Its cond_pass output gates register and flag writeback, including the xPSR write_en.
// PARAMETERS
//  None. Widths are fixed by ARMv7-M: ITSTATE is 8 bits, conditions are 4 bits.
// PORTS
//  clk            in   1  system clock, rising edge
//  rst            in   1  synchronous reset, active-high
//  apsr_nzcv      in   4  {N,Z,C,V} from the xPSR APSR read
//  it_start       in   1  IT instruction decoded and retiring this cycle (1-cycle strobe)
//  it_firstcond   in   4  IT firstcond field
//  it_mask        in   4  IT mask field, raw encoding
//  instr_advance  in   1  non-IT instruction retired this cycle
//  exc_clear      in   1  exception entry/return; clears ITSTATE
//  itstate        out  8  current ITSTATE, i.e. EPSR IT[7:0]
//  in_it_block    out  1  itstate[3:0] != 0
//  cur_cond       out  4  condition of the current instruction
//  cond_pass      out  1  the current instruction's condition holds
//  it_last        out  1  current instruction is the last one in the block
//  it_remaining   out  3  instructions left in the block, including the current one (0..4)
//  it_error       out  1  registered 1-cycle pulse: illegal IT was ignored
// BEHAVIOUR
//  Reset: itstate=8'h00, it_error=0. Combinational outputs then read:
//    in_it_block=0, cur_cond=4'b1110, cond_pass=1, it_last=0, it_remaining=0.
//  Output timing:
//    - itstate is registered; a load or advance is visible the cycle after the strobe.
//    - cur_cond, cond_pass, it_last, in_it_block and it_remaining are combinational
//      from itstate and apsr_nzcv.
//  Next-state priority, highest first:
//    1. rst -> itstate=0.
//    2. exc_clear -> itstate=0. This overrides it_start and instr_advance.
//    3. it_start:
//       - Legal when !in_it_block, it_mask!=0 and it_firstcond!=4'b1111.
//         Then itstate={it_firstcond,it_mask}. A simultaneous instr_advance is ignored.
//       - Otherwise it_error=1 next cycle and itstate is not loaded.
//         A simultaneous instr_advance still applies.
//    4. instr_advance while in_it_block:
//       - itstate[2:0]==3'b000 -> itstate=0.
//       - Else itstate[4:0] <= itstate[4:0]<<1, with itstate[7:5] held.
//    5. instr_advance while !in_it_block -> no change.
//  Decoded outputs:
//    - cur_cond = in_it_block ? itstate[7:4] : 4'b1110.
//    - it_last = (itstate[3:0]==4'b1000).
//    - it_remaining: 1000->1, x100->2, xx10->3, xxx1->4, 0000->0.
//  cond_pass, evaluated on cur_cond[3:1]:
//    - 000: Z
//    - 001: C
//    - 010: N
//    - 011: V
//    - 100: C&!Z
//    - 101: N==V
//    - 110: !Z&(N==V)
//    - 111: 1
//    - The result is inverted when cur_cond[0]=1 and cur_cond!=4'b1111.
//  State view: IDLE (itstate[3:0]==0) and IN_BLOCK (1-4 remaining).
//    - IDLE->IN_BLOCK only on a legal it_start.
//    - IN_BLOCK->IDLE on retiring the last instruction, on exc_clear, or on rst.
//  Reset mid-block: the block is abandoned and no output glitches past the reset edge.
//  it_error is cleared on any cycle with no illegal it_start.
// TESTING
//  1. Reset: hold rst 2 cycles.
//     -> itstate=00, in_it_block=0, cond_pass=1, cur_cond=E, it_remaining=0.
//  2. ITTE EQ: it_start, firstcond=0, mask=4'b0110, nzcv=4'b0100.
//     -> itstate=06, remaining=3, cond_pass=1.
//     advance -> itstate=0C, cond EQ, pass=1.
//     advance -> itstate=18, cond NE, it_last=1, pass=0.
//     advance -> itstate=00.
//  3. IT GE: firstcond=4'b1010, mask=4'b1000.
//     -> nzcv=4'b1000 gives pass=0; nzcv=4'b1001 gives pass=1.
//     advance -> in_it_block=0.
//  4. it_start while in a block (state 0C), with instr_advance in the same cycle.
//     -> it_error=1 for 1 cycle, itstate=18.
//     A separate it_start with mask=0 -> it_error=1, itstate stays 00.
//  5. exc_clear and it_start in the same cycle during ITTT.
//     -> itstate=00 next cycle, it_error=0.
//  6. rst asserted mid-block (itstate=0C) -> itstate=00 next cycle.
//     A new legal it_start after reset loads normally.

Source files
------------

// File: rtl/it_block_ctrl.sv
// ---------------------------------------------------------------------------
// it_block_ctrl
// Thumb-2 IT-block controller. Holds ITSTATE (EPSR IT[7:0]), evaluates the
// condition of the current instruction against the APSR flags, and advances
// ITSTATE as instructions retire. cond_pass gates writeback downstream.
//
// Ports
//   clk            in   1  system clock, rising edge
//   rst            in   1  synchronous reset, active-high
//   apsr_nzcv      in   4  {N,Z,C,V} from the APSR
//   it_start       in   1  IT instruction retiring this cycle
//   it_firstcond   in   4  IT firstcond field
//   it_mask        in   4  IT mask field, raw encoding
//   instr_advance  in   1  non-IT instruction retired this cycle
//   exc_clear      in   1  exception entry/return, clears ITSTATE
//   itstate        out  8  current ITSTATE (registered)
//   in_it_block    out  1  itstate[3:0] != 0
//   cur_cond       out  4  condition of the current instruction
//   cond_pass      out  1  current instruction's condition holds
//   it_last        out  1  current instruction is the last of the block
//   it_remaining   out  3  instructions left including the current one
//   it_error       out  1  registered pulse: an illegal IT was ignored
// ---------------------------------------------------------------------------
module it_block_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] apsr_nzcv,
    input  logic       it_start,
    input  logic [3:0] it_firstcond,
    input  logic [3:0] it_mask,
    input  logic       instr_advance,
    input  logic       exc_clear,
    output logic [7:0] itstate,
    output logic       in_it_block,
    output logic [3:0] cur_cond,
    output logic       cond_pass,
    output logic       it_last,
    output logic [2:0] it_remaining,
    output logic       it_error
);

    // ARM condition evaluation; the low bit inverts every base test except
    // for 4'b1111, which behaves as "always".
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic base;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            3'b111:  base = 1'b1;
            default: base = 1'b1;
        endcase
        if (cond[0] && (cond != 4'b1111)) begin
            cond_eval = ~base;
        end else begin
            cond_eval = base;
        end
    endfunction

    logic [7:0] itstate_r;
    logic [7:0] itstate_nxt_s;
    logic       it_error_r;
    logic       it_error_nxt_s;
    logic       in_block_s;
    logic       start_legal_s;

    assign in_block_s    = (itstate_r[3:0] != 4'b0000);
    assign start_legal_s = ~in_block_s && (it_mask != 4'b0000) && (it_firstcond != 4'b1111);

    // Next ITSTATE and error pulse, highest priority first.
    always_comb begin
        itstate_nxt_s  = itstate_r;
        it_error_nxt_s = 1'b0;
        if (exc_clear) begin
            itstate_nxt_s = 8'h00;
        end else if (it_start && start_legal_s) begin
            // A legal IT load wins over a simultaneous advance.
            itstate_nxt_s = {it_firstcond, it_mask};
        end else begin
            // An illegal IT is dropped, but a concurrent advance still retires.
            it_error_nxt_s = it_start;
            if (instr_advance && in_block_s) begin
                if (itstate_r[2:0] == 3'b000) begin
                    itstate_nxt_s = 8'h00;
                end else begin
                    // Base condition bits [7:5] stay; the mask shifts up.
                    itstate_nxt_s = {itstate_r[7:5], itstate_r[3:0], 1'b0};
                end
            end else begin
                itstate_nxt_s = itstate_r;
            end
        end
    end

    // State and error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            itstate_r  <= 8'h00;
            it_error_r <= 1'b0;
        end else begin
            itstate_r  <= itstate_nxt_s;
            it_error_r <= it_error_nxt_s;
        end
    end

    // Decoded view of the current ITSTATE.
    always_comb begin
        casez (itstate_r[3:0])
            4'b1000: it_remaining = 3'd1;
            4'b?100: it_remaining = 3'd2;
            4'b??10: it_remaining = 3'd3;
            4'b???1: it_remaining = 3'd4;
            default: it_remaining = 3'd0;
        endcase
    end

    assign itstate     = itstate_r;
    assign it_error    = it_error_r;
    assign in_it_block = in_block_s;
    assign cur_cond    = in_block_s ? itstate_r[7:4] : 4'b1110;
    assign it_last     = (itstate_r[3:0] == 4'b1000);
    assign cond_pass   = cond_eval(cur_cond, apsr_nzcv);

endmodule

// File: tb/tb_it_block_ctrl.sv
module tb_it_block_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] apsr_nzcv;
    logic       it_start;
    logic [3:0] it_firstcond;
    logic [3:0] it_mask;
    logic       instr_advance;
    logic       exc_clear;
    logic [7:0] itstate;
    logic       in_it_block;
    logic [3:0] cur_cond;
    logic       cond_pass;
    logic       it_last;
    logic [2:0] it_remaining;
    logic       it_error;

    int err_cnt = 0;
    int chk_cnt = 0;

    it_block_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .apsr_nzcv     (apsr_nzcv),
        .it_start      (it_start),
        .it_firstcond  (it_firstcond),
        .it_mask       (it_mask),
        .instr_advance (instr_advance),
        .exc_clear     (exc_clear),
        .itstate       (itstate),
        .in_it_block   (in_it_block),
        .cur_cond      (cur_cond),
        .cond_pass     (cond_pass),
        .it_last       (it_last),
        .it_remaining  (it_remaining),
        .it_error      (it_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        apsr_nzcv     = 4'b0000;
        it_start      = 1'b0;
        it_firstcond  = 4'b0000;
        it_mask       = 4'b0000;
        instr_advance = 1'b0;
        exc_clear     = 1'b0;

        // 1. Reset
        cyc(); cyc();
        rst = 1'b0;
        check_val("rst_itstate", itstate, 8'h00);
        check_val("rst_in_blk", {7'd0, in_it_block}, 8'h00);
        check_val("rst_pass", {7'd0, cond_pass}, 8'h01);
        check_val("rst_cond", {4'd0, cur_cond}, 8'h0E);
        check_val("rst_rem", {5'd0, it_remaining}, 8'h00);
        check_val("rst_last", {7'd0, it_last}, 8'h00);
        check_val("rst_err", {7'd0, it_error}, 8'h00);

        // 2. ITTE EQ with Z=1
        apsr_nzcv = 4'b0100;
        it_start = 1'b1; it_firstcond = 4'h0; it_mask = 4'b0110;
        cyc();
        it_start = 1'b0;
        check_val("itte_load", itstate, 8'h06);
        check_val("itte_rem3", {5'd0, it_remaining}, 8'h03);
        check_val("itte_pass1", {7'd0, cond_pass}, 8'h01);
        check_val("itte_inblk", {7'd0, in_it_block}, 8'h01);
        instr_advance = 1'b1;
        cyc();
        check_val("itte_adv1", itstate, 8'h0C);
        check_val("itte_cond1", {4'd0, cur_cond}, 8'h00);
        check_val("itte_pass2", {7'd0, cond_pass}, 8'h01);
        check_val("itte_rem2", {5'd0, it_remaining}, 8'h02);
        cyc();
        check_val("itte_adv2", itstate, 8'h18);
        check_val("itte_cond2", {4'd0, cur_cond}, 8'h01);
        check_val("itte_last", {7'd0, it_last}, 8'h01);
        check_val("itte_pass3", {7'd0, cond_pass}, 8'h00);
        check_val("itte_rem1", {5'd0, it_remaining}, 8'h01);
        cyc();
        instr_advance = 1'b0;
        check_val("itte_done", itstate, 8'h00);
        check_val("itte_idle", {7'd0, in_it_block}, 8'h00);

        // 3. IT GE
        apsr_nzcv = 4'b1000;
        it_start = 1'b1; it_firstcond = 4'b1010; it_mask = 4'b1000;
        cyc();
        it_start = 1'b0;
        check_val("ge_load", itstate, 8'hA8);
        check_val("ge_pass_nv", {7'd0, cond_pass}, 8'h00);
        check_val("ge_last", {7'd0, it_last}, 8'h01);
        apsr_nzcv = 4'b1001;
        #1;
        check_val("ge_pass_nv_eq", {7'd0, cond_pass}, 8'h01);
        instr_advance = 1'b1;
        cyc();
        instr_advance = 1'b0;
        check_val("ge_done", {7'd0, in_it_block}, 8'h00);

        // 4. Illegal IT inside a block, with concurrent advance
        it_start = 1'b1; it_firstcond = 4'h0; it_mask = 4'b0110;
        cyc();
        it_start = 1'b0; instr_advance = 1'b1;
        cyc();
        instr_advance = 1'b0;
        check_val("ill_pre", itstate, 8'h0C);
        it_start = 1'b1; it_firstcond = 4'h3; it_mask = 4'b1000; instr_advance = 1'b1;
        cyc();
        it_start = 1'b0; instr_advance = 1'b0;
        check_val("ill_adv", itstate, 8'h18);
        check_val("ill_err", {7'd0, it_error}, 8'h01);
        cyc();
        check_val("ill_err_clr", {7'd0, it_error}, 8'h00);
        check_val("ill_hold", itstate, 8'h18);
        instr_advance = 1'b1;
        cyc();
        instr_advance = 1'b0;
        check_val("ill_done", itstate, 8'h00);
        it_start = 1'b1; it_firstcond = 4'h0; it_mask = 4'b0000;
        cyc();
        it_start = 1'b0;
        check_val("mask0_err", {7'd0, it_error}, 8'h01);
        check_val("mask0_state", itstate, 8'h00);
        it_start = 1'b1; it_firstcond = 4'hF; it_mask = 4'b1000;
        cyc();
        it_start = 1'b0;
        check_val("fcF_err", {7'd0, it_error}, 8'h01);
        check_val("fcF_state", itstate, 8'h00);
        cyc();
        check_val("fcF_err_clr", {7'd0, it_error}, 8'h00);

        // 5. exc_clear overrides it_start during ITTT
        it_start = 1'b1; it_firstcond = 4'h0; it_mask = 4'b0001;
        cyc();
        it_start = 1'b0;
        check_val("ittt_load", itstate, 8'h01);
        check_val("ittt_rem4", {5'd0, it_remaining}, 8'h04);
        exc_clear = 1'b1; it_start = 1'b1; it_firstcond = 4'h2; it_mask = 4'b1000;
        cyc();
        exc_clear = 1'b0; it_start = 1'b0;
        check_val("exc_state", itstate, 8'h00);
        check_val("exc_err", {7'd0, it_error}, 8'h00);

        // 6. Reset mid-block, then a fresh load
        it_start = 1'b1; it_firstcond = 4'h0; it_mask = 4'b0110;
        cyc();
        it_start = 1'b0; instr_advance = 1'b1;
        cyc();
        instr_advance = 1'b0;
        check_val("mid_pre", itstate, 8'h0C);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_val("mid_rst", itstate, 8'h00);
        check_val("mid_rst_cond", {4'd0, cur_cond}, 8'h0E);
        apsr_nzcv = 4'b0100;
        it_start = 1'b1; it_firstcond = 4'h1; it_mask = 4'b1000;
        cyc();
        it_start = 1'b0;
        check_val("post_load", itstate, 8'h18);
        check_val("post_ne_pass", {7'd0, cond_pass}, 8'h00);
        instr_advance = 1'b1;
        cyc();
        instr_advance = 1'b0;
        it_start = 1'b1; it_firstcond = 4'hE; it_mask = 4'b1000;
        cyc();
        it_start = 1'b0;
        check_val("al_load", itstate, 8'hE8);
        check_val("al_pass", {7'd0, cond_pass}, 8'h01);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
